rx_block_sync: RTL and testbench

Receive block-lock controller for the 64b/66b PCS receive path. Sits between the receive gearbox and `decoder`: it tests the 2-bit sync header of every incoming 66-bit block and requests gearbox bit-slips until alignment is found. It maintains `block_lock` using the Clause 49 lock/unlock rules, and forwards blocks to the decoder only while locked.

---
 rtl/rx_block_sync_pkg.sv | 21 ++
 rtl/rx_block_sync.sv | 167 ++++++++++++++++
 tb/tb_rx_block_sync.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_block_sync_pkg.sv
// Shared 64b/66b PCS definitions: sync-header codes, block-lock state encoding
// and the default lock-window sizes used by the receive path and its benches.
package rx_block_sync_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int DEFAULT_SH_CNT_MAX   = 64;
  localparam int DEFAULT_SH_INVLD_MAX = 16;

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } sync_state_t;

  function automatic logic is_sync_header(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/rx_block_sync.sv
// Block-lock controller: tests 66b sync headers, requests gearbox bit-slips until
// aligned, tracks block_lock and forwards blocks to the decoder while locked.
module rx_block_sync
  import rx_block_sync_pkg::*;
#(
  parameter int PCS_DATA_WIDTH = 64,
  parameter int SH_CNT_MAX     = DEFAULT_SH_CNT_MAX,
  parameter int SH_INVLD_MAX   = DEFAULT_SH_INVLD_MAX,
  parameter int SLIP_WAIT      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PCS_DATA_WIDTH-1:0] in_encoded_data,
  input  logic [1:0]                in_encoded_header,
  input  logic                      in_encoded_valid,
  output logic                      out_slip,
  output logic                      out_block_lock,
  output logic [PCS_DATA_WIDTH-1:0] out_encoded_data,
  output logic [1:0]                out_encoded_header,
  output logic                      out_encoded_valid,
  output logic [7:0]                out_lock_loss_count
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX_V  = CNT_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_MAX_V  = INV_W'(SH_INVLD_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(SLIP_WAIT);

  sync_state_t               state_reg, state_next;
  logic [CNT_W-1:0]          sh_cnt_reg, sh_cnt_next;
  logic [INV_W-1:0]          sh_invld_cnt_reg, sh_invld_cnt_next;
  logic [WAIT_W-1:0]         wait_cnt_reg, wait_cnt_next;
  logic                      slip_reg, slip_next;
  logic                      lock_reg, lock_next;
  logic [7:0]                loss_cnt_reg, loss_cnt_next;
  logic [PCS_DATA_WIDTH-1:0] data_reg;
  logic [1:0]                header_reg;
  logic                      valid_reg;

  logic             hdr_ok;
  logic             tested;
  logic [CNT_W-1:0] sh_cnt_inc;
  logic [INV_W-1:0] invld_inc;
  logic             hunt_slip;
  logic             hunt_lock;
  logic             lock_fail;
  logic             window_end;
  logic             wait_done;

  assign hdr_ok     = is_sync_header(in_encoded_header);
  assign tested     = in_encoded_valid && (state_reg != ST_SLIP_WAIT);
  assign sh_cnt_inc = sh_cnt_reg + CNT_W'(1);
  assign invld_inc  = sh_invld_cnt_reg + {{(INV_W-1){1'b0}}, ~hdr_ok};

  assign hunt_slip  = tested && (state_reg == ST_HUNT) && !hdr_ok;
  assign hunt_lock  = tested && (state_reg == ST_HUNT) && hdr_ok && (sh_cnt_inc == CNT_MAX_V);
  // Lock loss takes priority over the window wrap when both land on one header.
  assign lock_fail  = tested && (state_reg == ST_LOCKED) && !hdr_ok && (invld_inc == INV_MAX_V);
  assign window_end = tested && (state_reg == ST_LOCKED) && !lock_fail && (sh_cnt_inc == CNT_MAX_V);
  assign wait_done  = (state_reg == ST_SLIP_WAIT) && (wait_cnt_reg <= WAIT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_HUNT;
      sh_cnt_reg       <= '0;
      sh_invld_cnt_reg <= '0;
      wait_cnt_reg     <= '0;
      slip_reg         <= 1'b0;
      lock_reg         <= 1'b0;
      loss_cnt_reg     <= '0;
      data_reg         <= '0;
      header_reg       <= '0;
      valid_reg        <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sh_cnt_reg       <= sh_cnt_next;
      sh_invld_cnt_reg <= sh_invld_cnt_next;
      wait_cnt_reg     <= wait_cnt_next;
      slip_reg         <= slip_next;
      lock_reg         <= lock_next;
      loss_cnt_reg     <= loss_cnt_next;
      valid_reg        <= in_encoded_valid && lock_reg;
      if (in_encoded_valid) begin
        data_reg   <= in_encoded_data;
        header_reg <= in_encoded_header;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HUNT: begin
        if (hunt_slip) begin
          state_next = ST_SLIP_WAIT;
        end else if (hunt_lock) begin
          state_next = ST_LOCKED;
        end
      end
      ST_SLIP_WAIT: begin
        if (wait_done) begin
          state_next = ST_HUNT;
        end
      end
      ST_LOCKED: begin
        if (lock_fail) begin
          state_next = ST_SLIP_WAIT;
        end
      end
      default: state_next = ST_HUNT;
    endcase
  end

  always_comb begin
    sh_cnt_next       = sh_cnt_reg;
    sh_invld_cnt_next = sh_invld_cnt_reg;
    wait_cnt_next     = wait_cnt_reg;
    slip_next         = 1'b0;
    lock_next         = lock_reg;
    loss_cnt_next     = loss_cnt_reg;

    if ((state_reg == ST_SLIP_WAIT) && (wait_cnt_reg != '0)) begin
      wait_cnt_next = wait_cnt_reg - WAIT_W'(1);
    end

    if (tested) begin
      sh_cnt_next = sh_cnt_inc;
      if (state_reg == ST_LOCKED) begin
        sh_invld_cnt_next = invld_inc;
      end
    end

    if (hunt_slip || lock_fail) begin
      slip_next         = 1'b1;
      sh_cnt_next       = '0;
      sh_invld_cnt_next = '0;
      wait_cnt_next     = WAIT_LOAD;
    end

    if (hunt_lock || window_end) begin
      sh_cnt_next       = '0;
      sh_invld_cnt_next = '0;
    end

    if (hunt_lock) begin
      lock_next = 1'b1;
    end

    if (lock_fail) begin
      lock_next = 1'b0;
      if (loss_cnt_reg != 8'hFF) begin
        loss_cnt_next = loss_cnt_reg + 8'd1;
      end
    end
  end

  assign out_slip            = slip_reg;
  assign out_block_lock      = lock_reg;
  assign out_encoded_data    = data_reg;
  assign out_encoded_header  = header_reg;
  assign out_encoded_valid   = valid_reg;
  assign out_lock_loss_count = loss_cnt_reg;

endmodule

// File: tb/tb_rx_block_sync.sv
// Bench for rx_block_sync: directed lock/unlock scenarios plus randomized traffic,
// all checked every cycle against a block-level model of the lock rules.
module tb_rx_block_sync;

  localparam int DW       = 64;
  localparam int WIN      = 64;
  localparam int BAD_MAX  = 16;
  localparam int WAIT_CYC = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_encoded_data;
  logic [1:0]    in_encoded_header;
  logic          in_encoded_valid;
  logic          out_slip;
  logic          out_block_lock;
  logic [DW-1:0] out_encoded_data;
  logic [1:0]    out_encoded_header;
  logic          out_encoded_valid;
  logic [7:0]    out_lock_loss_count;

  rx_block_sync dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_encoded_data     (in_encoded_data),
    .in_encoded_header   (in_encoded_header),
    .in_encoded_valid    (in_encoded_valid),
    .out_slip            (out_slip),
    .out_block_lock      (out_block_lock),
    .out_encoded_data    (out_encoded_data),
    .out_encoded_header  (out_encoded_header),
    .out_encoded_valid   (out_encoded_valid),
    .out_lock_loss_count (out_lock_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Model: what the outputs must be after the most recent clock edge.
  bit          m_locked;
  logic        m_slip;
  logic        m_valid;
  logic [DW-1:0] m_data;
  logic [1:0]  m_hdr;
  int          m_loss;
  int          m_ignore;   // upcoming edges at which headers are not examined
  int          m_run;      // headers seen in the current window / hunt run
  int          m_bad;      // invalid headers in the current locked window

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_locked = 0; m_slip = 0; m_valid = 0; m_data = '0; m_hdr = '0;
    m_loss = 0; m_ignore = 0; m_run = 0; m_bad = 0;
  endtask

  task automatic model_step(input logic v, input logic [1:0] h, input logic [DW-1:0] d);
    bit ok;
    m_valid = v && m_locked;
    if (v) begin
      m_data = d;
      m_hdr  = h;
    end
    m_slip = 0;
    ok = (h == 2'b01) || (h == 2'b10);
    if (m_ignore > 0) begin
      m_ignore--;
    end else if (v) begin
      m_run++;
      if (!m_locked) begin
        if (!ok) begin
          m_slip = 1; m_ignore = WAIT_CYC; m_run = 0;
        end else if (m_run == WIN) begin
          m_locked = 1; m_run = 0; m_bad = 0;
        end
      end else begin
        if (!ok) m_bad++;
        if (m_bad == BAD_MAX) begin
          m_locked = 0; m_slip = 1; m_ignore = WAIT_CYC;
          m_run = 0; m_bad = 0;
          if (m_loss < 255) m_loss++;
        end else if (m_run == WIN) begin
          m_run = 0; m_bad = 0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("slip", out_slip, m_slip);
      check("block_lock", out_block_lock, m_locked);
      check("enc_valid", out_encoded_valid, m_valid);
      check("enc_data", out_encoded_data, m_data);
      check("enc_header", out_encoded_header, m_hdr);
      check("loss_count", out_lock_loss_count, m_loss);
    end
  end

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  // Called aligned to a falling edge; returns on the next falling edge.
  task automatic drive(input logic v, input logic [1:0] h, input logic [DW-1:0] d);
    in_encoded_valid  = v;
    in_encoded_header = h;
    in_encoded_data   = d;
    @(posedge clk);
    model_step(v, h, d);
    @(negedge clk);
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, good_hdr(), rnd_data());
  endtask

  task automatic send_bad(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, bad_hdr(), rnd_data());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, '0);
  endtask

  initial begin
    int p_bad;
    logic [DW-1:0] d65;
    model_reset();
    rst = 1'b1;
    in_encoded_valid = 1'b0; in_encoded_header = 2'b00; in_encoded_data = '0;
    #3 rst = 1'b0;
    #1;
    check("rst_lock", out_block_lock, 0);
    check("rst_slip", out_slip, 0);
    check("rst_valid", out_encoded_valid, 0);
    check("rst_loss", out_lock_loss_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // Acquire lock: rises exactly on the 64th valid header.
    send_good(WIN - 1);
    check("lock_before_64", out_block_lock, 0);
    send_good(1);
    check("lock_after_64", out_block_lock, 1);
    check("first_lock_not_fwd", out_encoded_valid, 0);
    d65 = rnd_data();
    drive(1'b1, 2'b01, d65);
    check("blk65_valid", out_encoded_valid, 1);
    check("blk65_data", out_encoded_data, d65);

    // 15 invalid per window twice: lock held, window wraps.
    send_bad(BAD_MAX - 1);
    send_good(WIN - BAD_MAX);
    check("lock_15bad_w1", out_block_lock, 1);
    send_bad(BAD_MAX - 1);
    send_good(WIN - BAD_MAX + 1);
    check("lock_15bad_w2", out_block_lock, 1);

    // 16 invalid in one window: lock lost, last one still forwarded.
    send_bad(BAD_MAX - 1);
    check("lock_15bad_held", out_block_lock, 1);
    send_bad(1);
    check("loss_lock", out_block_lock, 0);
    check("loss_slip", out_slip, 1);
    check("loss_fwd", out_encoded_valid, 1);
    check("loss_count1", out_lock_loss_count, 1);

    // Headers ignored during the slip wait.
    for (int i = 0; i < WAIT_CYC; i++) begin
      send_bad(1);
      check("wait_no_slip", out_slip, 0);
    end

    // Hunt: 10 good then a 00 header gives one slip.
    send_good(10);
    drive(1'b1, 2'b00, rnd_data());
    check("hunt_slip", out_slip, 1);
    check("hunt_nolock", out_block_lock, 0);
    idle(1);
    check("hunt_slip_1cyc", out_slip, 0);
    idle(WAIT_CYC - 1);

    // 64th header of the window is also the 16th invalid: lock loss wins.
    send_good(WIN);
    check("relock", out_block_lock, 1);
    send_good(WIN - BAD_MAX);
    send_bad(BAD_MAX);
    check("coincide_lock", out_block_lock, 0);
    check("coincide_slip", out_slip, 1);
    check("coincide_loss", out_lock_loss_count, 2);
    idle(WAIT_CYC);

    // Randomized traffic with gaps and varying error rates.
    for (int ph = 0; ph < 15; ph++) begin
      case (ph % 5)
        0: p_bad = 0;
        1: p_bad = 1;
        2: p_bad = 3;
        3: p_bad = 8;
        default: p_bad = 25;
      endcase
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 99) < 85)
          drive(1'b1, ($urandom_range(0, 99) < p_bad) ? bad_hdr() : good_hdr(), rnd_data());
        else
          drive(1'b0, $urandom_range(0, 3), rnd_data());
      end
    end

    // Loss counter saturates at 255.
    for (int k = 0; k < 260; k++) begin
      idle(WAIT_CYC + 1);
      send_good(WIN);
      send_bad(BAD_MAX);
    end
    check("loss_sat", out_lock_loss_count, 255);

    // Asynchronous reset while locked.
    idle(WAIT_CYC + 1);
    for (int i = 0; i < 300 && !m_locked; i++) send_good(1);
    check("pre_rst_locked", out_block_lock, 1);
    #2 rst = 1'b0;
    chk_en = 1'b0;
    #1;
    check("arst_lock", out_block_lock, 0);
    check("arst_slip", out_slip, 0);
    check("arst_valid", out_encoded_valid, 0);
    check("arst_loss", out_lock_loss_count, 0);
    check("arst_data", out_encoded_data, 0);
    model_reset();
    in_encoded_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
    send_good(WIN - 1);
    check("post_rst_63", out_block_lock, 0);
    send_good(1);
    check("post_rst_64", out_block_lock, 1);
    idle(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
